// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control path: control-word field
// positions, forwarding select encodings and the bubble word.
package ctrl_pkg;

   localparam int CTRL_W = 9;
   localparam int REG_W  = 5;

   // WB field
   localparam int WB_REG_WRITE  = 8;
   localparam int WB_MEM_TO_REG = 7;
   // M field
   localparam int M_BRANCH      = 6;
   localparam int M_MEM_READ    = 5;
   localparam int M_MEM_WRITE   = 4;
   // EX field
   localparam int EX_REG_DST    = 3;
   localparam int EX_ALU_OP_HI  = 2;
   localparam int EX_ALU_OP_LO  = 1;
   localparam int EX_ALU_SRC    = 0;

   // ALU operand source selects
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   // All-zero control word: a no-op that writes nothing
   localparam logic [CTRL_W-1:0] BUBBLE = '0;

   typedef logic [REG_W-1:0] reg_num_t;

   // True when a stage that writes dst produces the value src needs.
   // Register 0 is hard-wired, so it never forwards.
   function automatic logic hits(input logic reg_write, input reg_num_t dst,
                                 input reg_num_t src);
      return reg_write && (dst != '0) && (dst == src);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one ALU operand: picks the youngest in-flight
// producer of the source register, or the register file if none.
module fwd_sel
   import ctrl_pkg::*;
(
   input  logic [4:0] src,
   input  logic       mem_reg_write,
   input  logic [4:0] mem_write_reg,
   input  logic       wb_reg_write,
   input  logic [4:0] wb_write_reg,
   output logic [1:0] sel
);

   // EX/MEM holds the newer value, so it is checked before MEM/WB
   always_comb begin
      sel = FWD_RF;
      if (hits(mem_reg_write, mem_write_reg, src)) begin
         sel = FWD_EXMEM;
      end else if (hits(wb_reg_write, wb_write_reg, src)) begin
         sel = FWD_MEMWB;
      end
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: carries the Decode control word through ID/EX, EX/MEM
// and MEM/WB, splits it into stage strobes, and derives load-use stall,
// taken-branch flush and EX-stage forwarding selects.
module ctrl_pipe
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] id_ctrl,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic [4:0] id_rd,
   input  logic       mem_zero,
   output logic       stall,
   output logic       flush_ifid,
   output logic       pc_src,
   output logic       ex_reg_dst,
   output logic       ex_alu_src,
   output logic [1:0] ex_alu_op,
   output logic       mem_branch,
   output logic       mem_read,
   output logic       mem_write,
   output logic       wb_reg_write,
   output logic       wb_mem_to_reg,
   output logic [4:0] wb_write_reg,
   output logic [1:0] fwd_a,
   output logic [1:0] fwd_b
);

   // ID/EX
   logic [8:0] ex_ctrl;
   logic [4:0] ex_rs;
   logic [4:0] ex_rt;
   logic [4:0] ex_rd;
   // EX/MEM keeps only the M and WB fields
   logic [8:4] mem_ctrl;
   logic [4:0] mem_write_reg;
   // MEM/WB keeps only the WB field
   logic [8:7] wb_ctrl;

   logic [4:0] ex_write_reg;

   assign ex_write_reg = ex_ctrl[EX_REG_DST] ? ex_rd : ex_rt;

   assign ex_reg_dst    = ex_ctrl[EX_REG_DST];
   assign ex_alu_op     = ex_ctrl[EX_ALU_OP_HI:EX_ALU_OP_LO];
   assign ex_alu_src    = ex_ctrl[EX_ALU_SRC];
   assign mem_branch    = mem_ctrl[M_BRANCH];
   assign mem_read      = mem_ctrl[M_MEM_READ];
   assign mem_write     = mem_ctrl[M_MEM_WRITE];
   assign wb_reg_write  = wb_ctrl[WB_REG_WRITE];
   assign wb_mem_to_reg = wb_ctrl[WB_MEM_TO_REG];

   // A taken branch resolves in MEM; it squashes the two younger stages.
   assign pc_src     = mem_branch & mem_zero;
   assign flush_ifid = pc_src;

   // Load in EX whose target is read by the instruction in ID. A flush
   // discards that instruction anyway, so it suppresses the stall.
   assign stall = ex_ctrl[M_MEM_READ] & (ex_rt != '0)
                & ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~pc_src;

   // ID/EX: bubble on flush or stall, otherwise capture Decode
   always_ff @(posedge clk) begin
      if (!rst_n || pc_src || stall) begin
         ex_ctrl <= BUBBLE;
         ex_rs   <= '0;
         ex_rt   <= '0;
         ex_rd   <= '0;
      end else begin
         ex_ctrl <= id_ctrl;
         ex_rs   <= id_rs;
         ex_rt   <= id_rt;
         ex_rd   <= id_rd;
      end
   end

   // EX/MEM: bubble on flush, otherwise advance (a stall still advances)
   always_ff @(posedge clk) begin
      if (!rst_n || pc_src) begin
         mem_ctrl      <= '0;
         mem_write_reg <= '0;
      end else begin
         mem_ctrl      <= ex_ctrl[WB_REG_WRITE:M_MEM_WRITE];
         mem_write_reg <= ex_write_reg;
      end
   end

   // MEM/WB: always advances; the branch itself retires normally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_ctrl      <= '0;
         wb_write_reg <= '0;
      end else begin
         wb_ctrl      <= mem_ctrl[WB_REG_WRITE:WB_MEM_TO_REG];
         wb_write_reg <= mem_write_reg;
      end
   end

   fwd_sel u_fwd_a (
      .src           (ex_rs),
      .mem_reg_write (mem_ctrl[WB_REG_WRITE]),
      .mem_write_reg (mem_write_reg),
      .wb_reg_write  (wb_reg_write),
      .wb_write_reg  (wb_write_reg),
      .sel           (fwd_a)
   );

   fwd_sel u_fwd_b (
      .src           (ex_rt),
      .mem_reg_write (mem_ctrl[WB_REG_WRITE]),
      .mem_write_reg (mem_write_reg),
      .wb_reg_write  (wb_reg_write),
      .wb_write_reg  (wb_write_reg),
      .sel           (fwd_b)
   );

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe. Each cycle the stimulus is driven just
// after the rising edge together with the hand-derived expectations for that
// cycle; the expectations are popped and compared on the falling edge.
module tb_ctrl_pipe;

   localparam logic [8:0] ALL   = 9'h1FF;
   localparam logic [8:0] RTYPE = 9'b10_000_1100;
   localparam logic [8:0] LW    = 9'b11_010_0001;
   localparam logic [8:0] SW    = 9'b00_001_0001;
   localparam logic [8:0] BEQ   = 9'b00_100_0000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] id_ctrl;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       mem_zero;
   logic       stall, flush_ifid, pc_src;
   logic       ex_reg_dst, ex_alu_src;
   logic [1:0] ex_alu_op;
   logic       mem_branch, mem_read, mem_write;
   logic       wb_reg_write, wb_mem_to_reg;
   logic [4:0] wb_write_reg;
   logic [1:0] fwd_a, fwd_b;

   always #5 clk = ~clk;

   ctrl_pipe dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_ctrl       (id_ctrl),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_rd         (id_rd),
      .mem_zero      (mem_zero),
      .stall         (stall),
      .flush_ifid    (flush_ifid),
      .pc_src        (pc_src),
      .ex_reg_dst    (ex_reg_dst),
      .ex_alu_src    (ex_alu_src),
      .ex_alu_op     (ex_alu_op),
      .mem_branch    (mem_branch),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_write_reg  (wb_write_reg),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b)
   );

   typedef enum int {S_STALL, S_FLUSH, S_PCSRC, S_FWDA, S_FWDB, S_EX, S_MEM, S_WB} sig_e;
   typedef struct {
      sig_e        sig;
      logic [15:0] val;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // EX = {reg_dst, alu_op, alu_src}, MEM = {branch, read, write},
   // WB = {reg_write, mem_to_reg, write_reg}
   function automatic logic [15:0] observe(input sig_e s);
      case (s)
         S_STALL: return {15'b0, stall};
         S_FLUSH: return {15'b0, flush_ifid};
         S_PCSRC: return {15'b0, pc_src};
         S_FWDA:  return {14'b0, fwd_a};
         S_FWDB:  return {14'b0, fwd_b};
         S_EX:    return {12'b0, ex_reg_dst, ex_alu_op, ex_alu_src};
         S_MEM:   return {13'b0, mem_branch, mem_read, mem_write};
         S_WB:    return {9'b0, wb_reg_write, wb_mem_to_reg, wb_write_reg};
         default: return 16'hFFFF;
      endcase
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic want(input sig_e s, input logic [15:0] v, input string tag);
      exp_t e;
      e.sig = s;
      e.val = v;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic z);
      id_ctrl  = c;
      id_rs    = rs;
      id_rt    = rt;
      id_rd    = rd;
      mem_zero = z;
      $display("t=%0t drive rst_n=%b ctrl=%b rs=%0d rt=%0d rd=%0d zero=%b",
               $time, rst_n, c, rs, rt, rd, z);
   endtask

   task automatic nop();
      drive(9'b0, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   // Compare this cycle's expectations on the falling edge, then advance
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, observe(e.sig), e.val);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) begin
         nop();
         cycle();
      end
   endtask

   task automatic want_reset_state(input string tag);
      want(S_STALL, 16'd0, {tag, "_stall"});
      want(S_FLUSH, 16'd0, {tag, "_flush"});
      want(S_PCSRC, 16'd0, {tag, "_pcsrc"});
      want(S_FWDA,  16'd0, {tag, "_fwda"});
      want(S_FWDB,  16'd0, {tag, "_fwdb"});
      want(S_EX,    16'd0, {tag, "_ex"});
      want(S_MEM,   16'd0, {tag, "_mem"});
      want(S_WB,    16'd0, {tag, "_wb"});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held for two edges with an all-ones word in ID
      rst_n = 1'b0;
      drive(ALL, 5'd1, 5'd2, 5'd3, 1'b1);
      @(posedge clk);
      #1;
      want_reset_state("rst1");
      cycle();
      want_reset_state("rst2");
      cycle();

      // Release: the word enters ID/EX on the next edge, WB two edges later
      rst_n = 1'b1;
      drive(ALL, 5'd1, 5'd2, 5'd3, 1'b0);
      want(S_EX, 16'd0, "rel_ex_empty");
      cycle();
      nop();
      want(S_EX, 16'hF, "rel_ex_word");
      want(S_STALL, 16'd0, "rel_no_stall");
      cycle();
      nop();
      want(S_MEM, 16'h7, "rel_mem_word");
      want(S_EX, 16'd0, "rel_ex_bubble");
      want(S_PCSRC, 16'd0, "rel_no_branch");
      cycle();
      nop();
      want(S_WB, 16'b11_00011, "rel_wb_word");
      cycle();
      drain();

      // Back-to-back R-type dependency: EX/MEM forward on A only
      drive(RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
      want(S_STALL, 16'd0, "rt_prod_stall");
      cycle();
      drive(RTYPE, 5'd3, 5'd4, 5'd6, 1'b0);
      want(S_EX, 16'b1100, "rt_prod_ex");
      want(S_FWDA, 16'd0, "rt_prod_fwda");
      cycle();
      nop();
      want(S_FWDA, 16'b10, "rt_cons_fwda");
      want(S_FWDB, 16'b00, "rt_cons_fwdb");
      want(S_MEM, 16'd0, "rt_prod_mem");
      cycle();
      nop();
      want(S_WB, 16'b10_00011, "rt_prod_wb");
      want(S_FWDA, 16'd0, "rt_bubble_fwda");
      cycle();
      drain();

      // One independent instruction between: MEM/WB forward on both
      drive(RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
      cycle();
      drive(RTYPE, 5'd7, 5'd8, 5'd9, 1'b0);
      cycle();
      drive(RTYPE, 5'd3, 5'd3, 5'd10, 1'b0);
      cycle();
      nop();
      want(S_FWDA, 16'b01, "gap_fwda");
      want(S_FWDB, 16'b01, "gap_fwdb");
      cycle();
      drain();

      // Both stages produce r3: the newer one in EX/MEM wins
      drive(RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
      cycle();
      drive(RTYPE, 5'd1, 5'd2, 5'd3, 1'b0);
      cycle();
      drive(RTYPE, 5'd3, 5'd3, 5'd4, 1'b0);
      cycle();
      nop();
      want(S_FWDA, 16'b10, "prio_fwda");
      want(S_FWDB, 16'b10, "prio_fwdb");
      cycle();
      drain();

      // Store strobes
      drive(SW, 5'd1, 5'd2, 5'd0, 1'b0);
      cycle();
      nop();
      want(S_EX, 16'b0001, "sw_ex");
      cycle();
      nop();
      want(S_MEM, 16'b001, "sw_mem");
      want(S_STALL, 16'd0, "sw_stall");
      cycle();
      drain();

      // Load-use: one stall, one bubble, then MEM/WB forward
      drive(LW, 5'd1, 5'd5, 5'd0, 1'b0);
      want(S_STALL, 16'd0, "lu_lw_stall");
      cycle();
      drive(RTYPE, 5'd5, 5'd6, 5'd7, 1'b0);
      want(S_STALL, 16'd1, "lu_stall");
      want(S_FLUSH, 16'd0, "lu_flush");
      want(S_EX, 16'b0001, "lu_lw_ex");
      cycle();
      drive(RTYPE, 5'd5, 5'd6, 5'd7, 1'b0);
      want(S_STALL, 16'd0, "lu_stall_once");
      want(S_EX, 16'd0, "lu_bubble_ex");
      want(S_FWDA, 16'd0, "lu_bubble_fwda");
      want(S_MEM, 16'b010, "lu_lw_mem");
      cycle();
      nop();
      want(S_EX, 16'b1100, "lu_dep_ex");
      want(S_FWDA, 16'b01, "lu_dep_fwda");
      want(S_FWDB, 16'b00, "lu_dep_fwdb");
      want(S_WB, 16'b11_00101, "lu_lw_wb");
      want(S_STALL, 16'd0, "lu_dep_stall");
      cycle();
      drain();

      // Register 0 never forwards
      drive(RTYPE, 5'd1, 5'd2, 5'd0, 1'b0);
      cycle();
      drive(RTYPE, 5'd0, 5'd0, 5'd4, 1'b0);
      cycle();
      nop();
      want(S_FWDA, 16'd0, "r0_mem_fwda");
      want(S_FWDB, 16'd0, "r0_mem_fwdb");
      cycle();
      nop();
      want(S_FWDA, 16'd0, "r0_wb_fwda");
      cycle();
      drain();

      // Register 0 never stalls
      drive(LW, 5'd1, 5'd0, 5'd0, 1'b0);
      cycle();
      drive(RTYPE, 5'd0, 5'd0, 5'd4, 1'b0);
      want(S_STALL, 16'd0, "r0_lw_stall");
      cycle();
      drain();

      // Taken branch: one-cycle flush, ID/EX and EX/MEM bubble
      drive(BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
      cycle();
      drive(RTYPE, 5'd1, 5'd2, 5'd8, 1'b1);
      want(S_PCSRC, 16'd0, "bt_zero_no_branch");
      want(S_STALL, 16'd0, "bt_stall");
      cycle();
      drive(RTYPE, 5'd1, 5'd2, 5'd9, 1'b1);
      want(S_PCSRC, 16'd1, "bt_pcsrc");
      want(S_FLUSH, 16'd1, "bt_flush");
      want(S_STALL, 16'd0, "bt_stall2");
      want(S_MEM, 16'b100, "bt_mem");
      want(S_EX, 16'b1100, "bt_ex");
      cycle();
      nop();
      want(S_PCSRC, 16'd0, "bt_pcsrc_once");
      want(S_FLUSH, 16'd0, "bt_flush_once");
      want(S_EX, 16'd0, "bt_ex_bubble");
      want(S_MEM, 16'd0, "bt_mem_bubble");
      want(S_WB, 16'b00_00010, "bt_wb");
      cycle();
      drain();

      // Not taken: nothing is squashed
      drive(BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
      cycle();
      drive(RTYPE, 5'd1, 5'd2, 5'd8, 1'b0);
      cycle();
      drive(RTYPE, 5'd1, 5'd2, 5'd9, 1'b0);
      want(S_PCSRC, 16'd0, "bn_pcsrc");
      want(S_FLUSH, 16'd0, "bn_flush");
      want(S_MEM, 16'b100, "bn_mem");
      cycle();
      nop();
      want(S_EX, 16'b1100, "bn_ex");
      cycle();
      nop();
      want(S_WB, 16'b10_01000, "bn_wb");
      cycle();
      drain();

      // Branch taken while a load-use is pending: flush wins
      drive(BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
      cycle();
      drive(LW, 5'd1, 5'd5, 5'd0, 1'b0);
      cycle();
      drive(RTYPE, 5'd5, 5'd6, 5'd7, 1'b1);
      want(S_STALL, 16'd0, "sim_stall");
      want(S_FLUSH, 16'd1, "sim_flush");
      want(S_PCSRC, 16'd1, "sim_pcsrc");
      want(S_EX, 16'b0001, "sim_ex_lw");
      want(S_MEM, 16'b100, "sim_mem_beq");
      cycle();
      nop();
      want(S_EX, 16'd0, "sim_ex_bubble");
      want(S_MEM, 16'd0, "sim_mem_bubble");
      want(S_WB, 16'b00_00010, "sim_wb");
      want(S_STALL, 16'd0, "sim_after_stall");
      cycle();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
